ledg_share_ctrl: RTL and testbench

- Controller for the 10 green LEDs (LEDG).
- Shares the LED bank between NREQ requesters using round-robin arbitration, with a minimum hold time per grant.
- When no requester holds the bank, it drives the default "bounce" pattern, advanced by an internal prescaled tick.
- Sits between status sources (debug, error, user logic) and the LEDG pins.

---
 rtl/ledg_pkg.sv | 33 +++
 rtl/ledg_tick_gen.sv | 29 ++
 rtl/ledg_share_ctrl.sv | 139 +++++++++++++
 tb/tb_ledg_share_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ledg_pkg.sv
// Shared types, constants and the round-robin picker for the LEDG sharing controller.
package ledg_pkg;

  localparam int LED_W   = 10;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ARB   = 2'd2
  } state_t;

  localparam logic [LED_W-1:0] BOUNCE_RST = 10'b0000000111;
  localparam logic [LED_W-1:0] TURN_R     = 10'b0111000000;
  localparam logic [LED_W-1:0] TURN_L     = 10'b0000001110;

  // Returns {found, index} of the first request after 'last', wrapping modulo n.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [3:0] res;
    int idx;
    res = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        idx = (int'(last) + i) % n;
        if (req[3'(idx)]) res = {1'b1, 3'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ledg_tick_gen.sv
// Free-running prescaler: oTICK pulses for one cycle after the count reaches TICK_DIV-1.
module ledg_tick_gen #(
  parameter int TICK_DIV = 1048576
) (
  input  logic iCLK,
  input  logic iRST_n,
  output logic oTICK
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          wrap;

  assign wrap  = (cnt_q == CW'(TICK_DIV - 1));
  assign oTICK = tick_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      tick_q <= wrap;
    end
  end

endmodule

// File: rtl/ledg_share_ctrl.sv
// Round-robin sharing of the green LED bank with a minimum hold per grant;
// idle bank shows a bouncing pattern that only advances while IDLE.
module ledg_share_ctrl
  import ledg_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int TICK_DIV   = 1048576,
  parameter int HOLD_TICKS = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic [NREQ-1:0]       iREQ,
  input  logic [LED_W*NREQ-1:0] iDATA,
  output logic [NREQ-1:0]       oGNT,
  output logic [LED_W-1:0]      oLED,
  output logic                  oTICK,
  output logic                  oBUSY
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_t             state_q;
  logic [NREQ-1:0]    gnt_q;
  logic [LED_W-1:0]   led_q;
  logic               busy_q;
  logic [LED_W-1:0]   bounce_q;
  logic               dir_q;      // 1 = moving right
  logic [HW-1:0]      hold_q;
  logic [2:0]         last_q;
  logic [2:0]         gidx_q;

  logic               tick;
  logic [MAX_REQ-1:0] req_ext;
  logic [3:0]         pick_idle;
  logic [3:0]         pick_arb;
  logic [LED_W-1:0]   grant_slice;
  logic               own_req;
  logic               other_req;
  logic               hold_done;
  logic               dir_d;
  logic [LED_W-1:0]   bounce_rot;
  logic [LED_W-1:0]   bounce_d;

  ledg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .oTICK  (tick)
  );

  assign oTICK = tick;
  assign oGNT  = gnt_q;
  assign oLED  = led_q;
  assign oBUSY = busy_q;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = iREQ;
  end

  // IDLE picks after the last finished grantee; ARB picks after the one just released.
  assign pick_idle = rr_pick(req_ext, last_q, NREQ);
  assign pick_arb  = rr_pick(req_ext, gidx_q, NREQ);

  always_comb begin
    grant_slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gidx_q) == i) grant_slice = iDATA[i*LED_W +: LED_W];
    end
  end

  assign own_req   = |(iREQ & gnt_q);
  assign other_req = |(iREQ & ~gnt_q);
  assign hold_done = (hold_q == HW'(HOLD_TICKS));

  // Turn decision is taken from the pre-shift pattern and steers this same step.
  always_comb begin
    dir_d = dir_q;
    if (bounce_q == TURN_R)      dir_d = 1'b1;
    else if (bounce_q == TURN_L) dir_d = 1'b0;
    bounce_rot = dir_d ? {bounce_q[0], bounce_q[LED_W-1:1]}
                       : {bounce_q[LED_W-2:0], bounce_q[LED_W-1]};
    bounce_d   = tick ? bounce_rot : bounce_q;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      led_q    <= BOUNCE_RST;
      busy_q   <= 1'b0;
      bounce_q <= BOUNCE_RST;
      dir_q    <= 1'b0;
      hold_q   <= '0;
      last_q   <= 3'(NREQ - 1);
      gidx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bounce_q <= bounce_d;
          if (tick) dir_q <= dir_d;
          led_q <= bounce_d;
          if (pick_idle[3]) begin
            state_q <= GRANT;
            gnt_q   <= NREQ'(1) << pick_idle[2:0];
            gidx_q  <= pick_idle[2:0];
            hold_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          led_q <= grant_slice;
          if (tick && !hold_done) hold_q <= hold_q + HW'(1);
          if (!own_req || (hold_done && other_req)) begin
            state_q <= ARB;
            gnt_q   <= '0;
          end
        end
        ARB: begin
          last_q <= gidx_q;
          if (pick_arb[3]) begin
            state_q <= GRANT;
            gnt_q   <= NREQ'(1) << pick_arb[2:0];
            gidx_q  <= pick_arb[2:0];
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ledg_share_ctrl.sv
// Directed bench for ledg_share_ctrl with TICK_DIV=4, HOLD_TICKS=2, NREQ=3.
module tb_ledg_share_ctrl;

  localparam int NREQ = 3;

  logic              iCLK = 1'b0;
  logic              iRST_n;
  logic [NREQ-1:0]   iREQ;
  logic [10*NREQ-1:0] iDATA;
  logic [NREQ-1:0]   oGNT;
  logic [9:0]        oLED;
  logic              oTICK;
  logic              oBUSY;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 iCLK = ~iCLK;

  ledg_share_ctrl #(.NREQ(NREQ), .TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iREQ   (iREQ),
    .iDATA  (iDATA),
    .oGNT   (oGNT),
    .oLED   (oLED),
    .oTICK  (oTICK),
    .oBUSY  (oBUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Returns at the negedge just after the edge that consumed the next tick.
  task automatic wait_tick();
    int k = 0;
    while (!oTICK && k < 8) begin
      @(negedge iCLK);
      k++;
    end
    chk("tick_seen", 32'(oTICK), 32'd1);
    @(negedge iCLK);
  endtask

  logic [9:0] exp_b [0:12];
  int bad, ticks;

  initial begin
    exp_b = '{10'h007, 10'h00E, 10'h01C, 10'h038, 10'h070, 10'h0E0, 10'h1C0,
              10'h0E0, 10'h070, 10'h038, 10'h01C, 10'h00E, 10'h01C};
    iRST_n = 1'b0;
    iREQ   = '0;
    iDATA  = {10'h3C3, 10'h155, 10'h2AA};
    step(2);
    chk("rst_gnt", 32'(oGNT), 32'd0);
    chk("rst_led", 32'(oLED), 32'h007);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_tick", 32'(oTICK), 32'd0);
    iRST_n = 1'b1;

    // Idle bounce with both reversals
    for (int i = 1; i <= 12; i++) begin
      wait_tick();
      chk($sformatf("bounce%0d", i), 32'(oLED), 32'(exp_b[i]));
    end
    chk("idle_busy", 32'(oBUSY), 32'd0);

    // Single request: grant after one edge, data after the next
    iREQ = 3'b001;
    step(1);
    chk("g0_gnt", 32'(oGNT), 32'b001);
    chk("g0_busy", 32'(oBUSY), 32'd1);
    chk("g0_led_frozen", 32'(oLED), 32'h01C);
    step(1);
    chk("g0_led_data", 32'(oLED), 32'h2AA);

    // Held alone for 20 ticks: no gaps, non-grantee data ignored
    iDATA[19:10] = 10'h0F0;
    bad = 0;
    ticks = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (oGNT !== 3'b001) bad++;
      if (oTICK) ticks++;
    end
    chk("hold_gaps", 32'(bad), 32'd0);
    chk("hold_ticks", 32'(ticks), 32'd20);
    chk("hold_led", 32'(oLED), 32'h2AA);
    iDATA[19:10] = 10'h155;

    // Release: ARB one cycle, IDLE, frozen bounce resumes
    wait_tick();
    iREQ = 3'b000;
    step(1);
    chk("rel_arb_gnt", 32'(oGNT), 32'd0);
    chk("rel_arb_busy", 32'(oBUSY), 32'd1);
    step(1);
    chk("rel_idle_busy", 32'(oBUSY), 32'd0);
    step(1);
    chk("rel_led_frozen", 32'(oLED), 32'h01C);
    step(1);
    chk("rel_led_resume", 32'(oLED), 32'h038);

    // All three requesting: 1 -> 2 -> 0 -> 1, preempted after 2 ticks each
    wait_tick();
    chk("rr_led_idle", 32'(oLED), 32'h070);
    iREQ = 3'b111;
    step(1);
    chk("rr_g1", 32'(oGNT), 32'b010);
    step(7);
    chk("rr_g1_held", 32'(oGNT), 32'b010);
    step(1);
    chk("rr_gap1", 32'(oGNT), 32'd0);
    chk("rr_gap1_busy", 32'(oBUSY), 32'd1);
    step(1);
    chk("rr_g2", 32'(oGNT), 32'b100);
    step(1);
    chk("rr_g2_led", 32'(oLED), 32'h3C3);
    step(5);
    chk("rr_g2_held", 32'(oGNT), 32'b100);
    step(1);
    chk("rr_gap2", 32'(oGNT), 32'd0);
    step(1);
    chk("rr_g0", 32'(oGNT), 32'b001);
    step(1);
    chk("rr_g0_led", 32'(oLED), 32'h2AA);
    step(5);
    chk("rr_g0_held", 32'(oGNT), 32'b001);
    step(1);
    chk("rr_gap3", 32'(oGNT), 32'd0);
    step(1);
    chk("rr_g1_again", 32'(oGNT), 32'b010);

    // Grantee 1 drops before any tick
    iREQ = 3'b000;
    step(1);
    chk("drop_arb_gnt", 32'(oGNT), 32'd0);
    chk("drop_arb_busy", 32'(oBUSY), 32'd1);
    step(1);
    chk("drop_idle_busy", 32'(oBUSY), 32'd0);
    step(1);
    chk("drop_led_frozen", 32'(oLED), 32'h070);
    step(3);
    chk("drop_led_resume", 32'(oLED), 32'h0E0);

    // Grant 0 then release, so requester 1 wins next from {0,1}
    iREQ = 3'b001;
    step(1);
    chk("pre_g0", 32'(oGNT), 32'b001);
    iREQ = 3'b000;
    step(1);
    chk("pre_arb", 32'(oGNT), 32'd0);
    step(1);
    chk("pre_idle_busy", 32'(oBUSY), 32'd0);
    iREQ = 3'b011;
    step(1);
    chk("pre_g1", 32'(oGNT), 32'b010);
    step(2);
    chk("pre_g1_led", 32'(oLED), 32'h155);

    // Asynchronous reset mid-grant
    #2;
    iRST_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(oGNT), 32'd0);
    chk("arst_led", 32'(oLED), 32'h007);
    chk("arst_busy", 32'(oBUSY), 32'd0);
    chk("arst_tick", 32'(oTICK), 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    step(1);
    chk("post_rst_g0", 32'(oGNT), 32'b001);
    chk("post_rst_busy", 32'(oBUSY), 32'd1);
    step(1);
    chk("post_rst_led", 32'(oLED), 32'h2AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
